// File: rtl/button_pulse_gen_pkg.sv
// Shared types and constants for the push-button pulse generator.
// The channel state encoding and channel index constants live here.
package button_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } ch_state_e;

  localparam int NUM_CH = 3;
  localparam int COIN   = 0;
  localparam int START  = 1;
  localparam int STOP   = 2;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter and 4-state FSM.
// Emits one registered clock-wide pulse per accepted press and a debounced level.
//
// state           | meaning
// ST_IDLE         | button released and debounced
// ST_PRESS_WAIT   | input high, counting stable cycles before accepting a press
// ST_PRESSED      | press accepted, waiting for release
// ST_RELEASE_WAIT | input low, counting stable cycles before accepting release
module btn_debounce_ch
  import button_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             s;

  assign s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // The pulse defaults low, so it always drops one cycle after being set.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pulse = pulse_q;
  assign level = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);

endmodule

// File: rtl/button_pulse_gen.sv
// Conditions the coin, start and stop push-buttons into single-cycle command
// pulses for the main machine FSM; channels are fully independent.
module button_pulse_gen
  import button_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_COIN,
  input  logic       BTN_START,
  input  logic       BTN_STOP,
  output logic       C_IN,
  output logic       GAME_START,
  output logic       SBTN,
  output logic [2:0] BTN_STATE
);

  logic [NUM_CH-1:0] btn_raw;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] level;

  assign btn_raw[COIN]  = BTN_COIN;
  assign btn_raw[START] = BTN_START;
  assign btn_raw[STOP]  = BTN_STOP;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk    (CLK),
      .rst_n  (RST),
      .btn_raw(btn_raw[i]),
      .pulse  (pulse[i]),
      .level  (level[i])
    );
  end

  assign C_IN       = pulse[COIN];
  assign GAME_START = pulse[START];
  assign SBTN       = pulse[STOP];
  assign BTN_STATE  = level;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen with a run-length reference model:
// a channel's debounced level flips once the synchronised input has disagreed
// with it for DEB+1 consecutive samples; a 0->1 flip is a pulse.
module tb_button_pulse_gen;

  localparam int DEB = 4;

  logic       CLK       = 1'b0;
  logic       RST       = 1'b0;
  logic       BTN_COIN  = 1'b0;
  logic       BTN_START = 1'b0;
  logic       BTN_STOP  = 1'b0;
  logic       C_IN;
  logic       GAME_START;
  logic       SBTN;
  logic [2:0] BTN_STATE;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [2:0] raw_d1  = '0;
  logic [2:0] raw_d2  = '0;
  logic [2:0] m_lvl   = '0;
  logic [2:0] m_pulse = '0;
  int         m_run[3] = '{0, 0, 0};

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_COIN  (BTN_COIN),
    .BTN_START (BTN_START),
    .BTN_STOP  (BTN_STOP),
    .C_IN      (C_IN),
    .GAME_START(GAME_START),
    .SBTN      (SBTN),
    .BTN_STATE (BTN_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      raw_d1  = '0;
      raw_d2  = '0;
      m_lvl   = '0;
      m_pulse = '0;
      m_run   = '{0, 0, 0};
    end else begin
      logic [2:0] s;
      s       = raw_d2;
      raw_d2  = raw_d1;
      raw_d1  = {BTN_STOP, BTN_START, BTN_COIN};
      m_pulse = '0;
      for (int i = 0; i < 3; i++) begin
        if (s[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_lvl[i]   = s[i];
            m_pulse[i] = s[i];
            m_run[i]   = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("mdl_c_in",       32'(C_IN),       32'(m_pulse[0]));
    chk("mdl_game_start", 32'(GAME_START), 32'(m_pulse[1]));
    chk("mdl_sbtn",       32'(SBTN),       32'(m_pulse[2]));
    chk("mdl_btn_state",  32'(BTN_STATE),  32'(m_lvl));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  logic [2:0] rnd_btn;
  int         run_left[3];
  int         n;
  int         flag;
  int         pedge;

  initial begin
    // reset held with coin pressed
    BTN_COIN = 1'b1;
    cyc(3);
    chk("rst_c_in",  32'(C_IN),      32'd0);
    chk("rst_state", 32'(BTN_STATE), 32'd0);
    RST = 1'b1;
    n = 0; pedge = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (C_IN) begin n++; pedge = i; end
    end
    chk("rst_pulse_cnt",  n,               1);
    chk("rst_pulse_edge", pedge,           6);
    chk("rst_lvl",        32'(BTN_STATE),  32'd1);
    BTN_COIN = 1'b0;
    cyc(12);

    // glitch on start
    flag = 0;
    BTN_START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (GAME_START || BTN_STATE[1]) flag++;
    end
    BTN_START = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (GAME_START || BTN_STATE[1]) flag++;
    end
    chk("glitch_seen", flag, 0);

    // release bounce on stop
    n = 0; flag = 0;
    BTN_STOP = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (SBTN) n++;
    end
    for (int j = 0; j < 6; j++) begin
      BTN_STOP = (j % 2 == 1);
      @(negedge CLK);
      if (SBTN) n++;
      if (!BTN_STATE[2]) flag++;
    end
    BTN_STOP = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (SBTN) n++;
      if (!BTN_STATE[2]) flag++;
    end
    chk("bounce_pulses", n,    1);
    chk("bounce_drop",   flag, 0);
    BTN_STOP = 1'b0;
    cyc(12);

    // long hold on coin
    n = 0;
    BTN_COIN = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (C_IN) n++;
    end
    chk("hold_pulses", n, 1);
    BTN_COIN = 1'b0;
    cyc(6);
    chk("hold_lvl_pre", 32'(BTN_STATE[0]), 32'd1);
    cyc(1);
    chk("hold_lvl_rel", 32'(BTN_STATE[0]), 32'd0);
    cyc(4);

    // repeated clean presses
    n = 0;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 20; i++) begin
        BTN_COIN = (i < 10);
        @(negedge CLK);
        if (C_IN) begin
          n++;
          chk("rep_lat", i, 6);
        end
      end
    end
    chk("rep_pulses", n, 5);

    // simultaneous coin and stop
    n = 0;
    BTN_COIN = 1'b1;
    BTN_STOP = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (C_IN) begin
        n++;
        chk("sim_sbtn", 32'(SBTN), 32'd1);
        chk("sim_lat",  i,         6);
      end
    end
    chk("sim_pulses", n, 1);
    BTN_COIN = 1'b0;
    BTN_STOP = 1'b0;
    cyc(10);

    // async reset mid press-wait, then fresh press after release
    BTN_COIN = 1'b1;
    cyc(4);
    #2 RST = 1'b0;
    #1;
    chk("arst_pw_state", 32'(BTN_STATE), 32'd0);
    chk("arst_pw_c_in",  32'(C_IN),      32'd0);
    @(negedge CLK);
    RST = 1'b1;
    n = 0; pedge = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (C_IN) begin n++; pedge = i; end
    end
    chk("arst_re_cnt",  n,     1);
    chk("arst_re_edge", pedge, 6);
    chk("arst_pr_pre",  32'(BTN_STATE), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("arst_pr_state", 32'(BTN_STATE), 32'd0);
    @(negedge CLK);
    BTN_COIN = 1'b0;
    RST = 1'b1;
    cyc(8);

    // randomized run lengths on all channels with occasional async reset
    rnd_btn = '0;
    run_left = '{0, 0, 0};
    for (int c = 0; c < 4000; c++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (run_left[ch] == 0) begin
          rnd_btn[ch]  = ~rnd_btn[ch];
          run_left[ch] = int'($urandom_range(1, 12));
        end
        run_left[ch]--;
      end
      {BTN_STOP, BTN_START, BTN_COIN} = rnd_btn;
      if ($urandom_range(0, 799) == 0) begin
        #2 RST = 1'b0;
        #1;
        chk("rnd_rst_state", 32'(BTN_STATE), 32'd0);
      end
      @(negedge CLK);
      RST = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
